interrupt_controller: RTL and testbench

Collects interrupt requests from peripheral blocks such as the countdown timer and merges them into one CPU interrupt line. Sources are latched on rising edges, masked, and priority-encoded into a readable vector. The CPU acknowledges a source by writing its index. The controller then returns a one-cycle `interrupt_clear` pulse to that source, closing the loop that each peripheral's `interrupt` / `interrupt_clear` pair expects. The block sits between the peripheral interrupt outputs and the CPU bus, on the system clock.

---
 rtl/interrupt_controller.sv | 157 +++++++++++++++
 tb/tb_interrupt_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-latched, masked, priority-encoded interrupt controller
//
// Purpose:
//   Latches rising edges on peripheral interrupt lines into a pending register,
//   masks them, drives a single registered CPU interrupt and exposes the
//   highest-priority (lowest index) active source as a readable vector. A CPU
//   write of a source index to the ACK register clears that source and sends a
//   one-cycle clear pulse back to the peripheral.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   irq_in     peripheral interrupt levels, one bit per source
//   irq_clear  one-cycle one-hot clear pulse back to the acknowledged source
//   nwr        active-low write strobe (a write on every edge it is low)
//   nrd        active-low read strobe (data_out loaded on that edge)
//   address    register select: 0 MASK, 1 PENDING, 2 ACK/VECTOR, 3 SWSET/RAW
//   data_in    write data
//   data_out   registered read data
//   cpu_irq    registered CPU interrupt request

module interrupt_controller #(
    parameter int SOURCES    = 8,
    parameter int INDEX_BITS = 3,
    parameter int DATA_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SOURCES-1:0]    irq_in,
    output logic [SOURCES-1:0]    irq_clear,
    input  logic                  nwr,
    input  logic                  nrd,
    input  logic [1:0]            address,
    input  logic [DATA_BITS-1:0]  data_in,
    output logic [DATA_BITS-1:0]  data_out,
    output logic                  cpu_irq
);

    typedef enum logic {
        ACK_IDLE  = 1'b0,
        ACK_PULSE = 1'b1
    } ack_state_t;

    localparam logic [SOURCES-1:0] ONE = {{(SOURCES-1){1'b0}}, 1'b1};

    logic [SOURCES-1:0]    mask;
    logic [SOURCES-1:0]    pending;
    logic [SOURCES-1:0]    irq_prev;
    logic [SOURCES-1:0]    active;
    logic [SOURCES-1:0]    set_bits;
    logic [SOURCES-1:0]    clr_bits;
    logic [INDEX_BITS-1:0] ack_n;
    logic [INDEX_BITS-1:0] ack_index;
    logic [INDEX_BITS-1:0] ack_index_next;
    logic [INDEX_BITS-1:0] vec_index;
    logic                  vec_valid;
    logic                  ack_valid;
    logic                  wr_mask;
    logic                  wr_pending;
    logic                  wr_ack;
    logic                  wr_swset;
    logic [DATA_BITS-1:0]  read_word;
    ack_state_t            state;
    ack_state_t            state_next;
    logic                  unused_data;

    // Only the low SOURCES / INDEX_BITS bits of the write data carry meaning.
    assign unused_data = ^data_in;

    assign wr_mask    = !nwr && (address == 2'd0);
    assign wr_pending = !nwr && (address == 2'd1);
    assign wr_ack     = !nwr && (address == 2'd2);
    assign wr_swset   = !nwr && (address == 2'd3);

    // Indices beyond the implemented sources are silently dropped.
    assign ack_n     = data_in[INDEX_BITS-1:0];
    assign ack_valid = wr_ack && (32'(ack_n) < SOURCES);

    assign active = pending & mask;

    // Sets are applied after clears so a same-edge set always wins.
    assign set_bits = (irq_in & ~irq_prev) | (wr_swset ? data_in[SOURCES-1:0] : '0);
    assign clr_bits = (wr_pending ? data_in[SOURCES-1:0] : '0)
                    | (ack_valid ? (ONE << ack_n) : '0);

    // Lowest active index wins: scan downward so the last hit is the lowest.
    always_comb begin
        vec_valid = 1'b0;
        vec_index = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (active[i]) begin
                vec_valid = 1'b1;
                vec_index = INDEX_BITS'(i);
            end
        end
    end

    always_comb begin
        read_word = '0;
        case (address)
            2'd0: read_word = DATA_BITS'(mask);
            2'd1: read_word = DATA_BITS'(pending);
            2'd2: begin
                read_word[DATA_BITS-1]    = vec_valid;
                read_word[INDEX_BITS-1:0] = vec_index;
            end
            default: read_word = DATA_BITS'(irq_in);
        endcase
    end

    // Acknowledge pulse FSM: a new valid ACK always (re)enters PULSE with its
    // own index, so back-to-back ACKs produce back-to-back one-hot pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACK_IDLE;
            ack_index <= '0;
        end else begin
            state     <= state_next;
            ack_index <= ack_index_next;
        end
    end

    always_comb begin
        state_next     = ACK_IDLE;
        ack_index_next = ack_index;
        irq_clear      = '0;
        if (ack_valid) begin
            state_next     = ACK_PULSE;
            ack_index_next = ack_n;
        end
        if (state == ACK_PULSE) begin
            irq_clear = ONE << ack_index;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask     <= '0;
            pending  <= '0;
            irq_prev <= '0;
            cpu_irq  <= 1'b0;
            data_out <= '0;
        end else begin
            irq_prev <= irq_in;
            pending  <= (pending & ~clr_bits) | set_bits;
            cpu_irq  <= |active;
            if (wr_mask) begin
                mask <= data_in[SOURCES-1:0];
            end
            // Read captures pre-write state when nrd and nwr are both low.
            if (!nrd) begin
                data_out <= read_word;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - self-checking bench for interrupt_controller

module tb_interrupt_controller;

    logic        clk;
    logic        reset;
    logic [7:0]  irq_in;
    logic [7:0]  irq_clear;
    logic        nwr;
    logic        nrd;
    logic [1:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        cpu_irq;

    logic [7:0]  sw_irq;
    logic        tmr_irq;
    logic        tmr_load;
    logic [3:0]  tmr_count;
    logic        cmp_en;

    int checks = 0;
    int passed = 0;

    // Four index bits with eight sources so that an out-of-range ACK index
    // (such as 9) is representable.
    interrupt_controller #(
        .SOURCES(8),
        .INDEX_BITS(4),
        .DATA_BITS(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .irq_in(irq_in),
        .irq_clear(irq_clear),
        .nwr(nwr),
        .nrd(nrd),
        .address(address),
        .data_in(data_in),
        .data_out(data_out),
        .cpu_irq(cpu_irq)
    );

    assign irq_in = sw_irq | {2'b00, tmr_irq, 5'b00000};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Countdown timer peripheral on source 5: raises interrupt when the count
    // expires and holds it until its clear pulse arrives.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_count <= 4'd0;
            tmr_irq   <= 1'b0;
        end else begin
            if (tmr_load) begin
                tmr_count <= 4'd2;
            end else if (tmr_count != 4'd0) begin
                tmr_count <= tmr_count - 4'd1;
                if (tmr_count == 4'd1) tmr_irq <= 1'b1;
            end
            if (irq_clear[5]) tmr_irq <= 1'b0;
        end
    end

    // Reference model: what the controller must show after each edge.
    logic [7:0]  m_mask = '0, m_pend = '0, m_prev = '0, m_clr = '0;
    logic        m_cpu = 1'b0;
    logic [31:0] m_dout = '0;
    logic [7:0]  n_mask, n_pend, n_clr;
    logic        n_cpu;
    logic [31:0] n_dout;

    always_comb begin
        n_mask = m_mask;
        n_pend = m_pend;
        n_clr  = '0;
        n_dout = m_dout;
        n_cpu  = (m_pend & m_mask) != 8'h00;
        if (!nrd) begin
            case (address)
                2'd0: n_dout = {24'h0, m_mask};
                2'd1: n_dout = {24'h0, m_pend};
                2'd2: begin
                    n_dout = 32'h0;
                    for (int n = 7; n >= 0; n--)
                        if (m_pend[n] && m_mask[n]) n_dout = 32'h8000_0000 + 32'(n);
                end
                default: n_dout = {24'h0, irq_in};
            endcase
        end
        if (!nwr && address == 2'd1) n_pend = n_pend & ~data_in[7:0];
        if (!nwr && address == 2'd2 && data_in[3:0] < 4'd8) begin
            n_pend[data_in[2:0]] = 1'b0;
            n_clr[data_in[2:0]]  = 1'b1;
        end
        for (int n = 0; n < 8; n++)
            if (irq_in[n] && !m_prev[n]) n_pend[n] = 1'b1;
        if (!nwr && address == 2'd3) n_pend = n_pend | data_in[7:0];
        if (!nwr && address == 2'd0) n_mask = data_in[7:0];
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mask <= '0; m_pend <= '0; m_prev <= '0; m_clr <= '0;
            m_cpu  <= 1'b0; m_dout <= '0;
        end else begin
            m_mask <= n_mask; m_pend <= n_pend; m_prev <= irq_in; m_clr <= n_clr;
            m_cpu  <= n_cpu;  m_dout <= n_dout;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_cpu_irq",   {31'h0, cpu_irq}, {31'h0, m_cpu});
            chk("model_irq_clear", {24'h0, irq_clear}, {24'h0, m_clr});
            chk("model_data_out",  data_out, m_dout);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        nwr = 1'b0; address = a; data_in = d;
        cyc();
        nwr = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        nrd = 1'b0; address = a;
        cyc();
        nrd = 1'b1;
    endtask

    initial begin
        reset = 1'b0; nwr = 1'b1; nrd = 1'b1; address = 2'd0; data_in = 32'h0;
        sw_irq = 8'h00; tmr_load = 1'b0; cmp_en = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cpu_irq",   {31'h0, cpu_irq}, 32'h0);
        chk("reset_irq_clear", {24'h0, irq_clear}, 32'h0);
        chk("reset_data_out",  data_out, 32'h0);
        reset = 1'b0;
        cmp_en = 1'b1;
        repeat (3) cyc();
        chk("idle_cpu_irq", {31'h0, cpu_irq}, 32'h0);
        rd(2'd2);
        chk("idle_vector", data_out, 32'h0);

        // Single source through mask, vector and acknowledge
        wr(2'd0, 32'h05);
        sw_irq = 8'h04;
        cyc();
        chk("e0_cpu_irq_low", {31'h0, cpu_irq}, 32'h0);
        cyc();
        chk("e1_cpu_irq_high", {31'h0, cpu_irq}, 32'h1);
        sw_irq = 8'h00;
        rd(2'd1);
        chk("pending_0x04", data_out, 32'h04);
        rd(2'd2);
        chk("vector_src2", data_out, 32'h8000_0002);
        wr(2'd2, 32'h2);
        chk("ack2_pulse", {24'h0, irq_clear}, 32'h04);
        cyc();
        chk("ack2_pulse_end", {24'h0, irq_clear}, 32'h0);
        chk("ack2_cpu_irq_low", {31'h0, cpu_irq}, 32'h0);

        // Priority between simultaneous sources
        wr(2'd0, 32'hFF);
        sw_irq = 8'h05;
        cyc();
        sw_irq = 8'h00;
        cyc();
        rd(2'd2);
        chk("vector_prio0", data_out, 32'h8000_0000);
        wr(2'd2, 32'h0);
        rd(2'd2);
        chk("vector_after_ack0", data_out, 32'h8000_0002);
        wr(2'd2, 32'h2);
        cyc();

        // Set and acknowledge on the same edge: set wins, pulse still issued
        sw_irq = 8'h08;
        cyc();
        sw_irq = 8'h00;
        cyc();
        chk("conflict_pre_cpu", {31'h0, cpu_irq}, 32'h1);
        sw_irq = 8'h08;
        wr(2'd2, 32'h3);
        chk("conflict_pulse", {24'h0, irq_clear}, 32'h08);
        cyc();
        chk("conflict_cpu_held", {31'h0, cpu_irq}, 32'h1);
        rd(2'd1);
        chk("conflict_pending", data_out, 32'h08);
        sw_irq = 8'h00;

        // Software set and out-of-range acknowledge
        wr(2'd1, 32'hFF);
        wr(2'd0, 32'h80);
        cyc();
        chk("swset_pre_cpu", {31'h0, cpu_irq}, 32'h0);
        wr(2'd3, 32'h80);
        cyc();
        chk("swset_cpu_irq", {31'h0, cpu_irq}, 32'h1);
        wr(2'd2, 32'h9);
        chk("ack9_no_pulse", {24'h0, irq_clear}, 32'h0);
        rd(2'd1);
        chk("ack9_pending", data_out, 32'h80);

        // Read and write on the same edge: read sees the old mask
        nrd = 1'b0; nwr = 1'b0; address = 2'd0; data_in = 32'h11;
        cyc();
        nrd = 1'b1; nwr = 1'b1;
        chk("rdwr_old_mask", data_out, 32'h80);
        rd(2'd0);
        chk("rdwr_new_mask", data_out, 32'h11);

        // Timer loop: interrupt, acknowledge, interrupt drops
        wr(2'd1, 32'hFF);
        wr(2'd0, 32'h20);
        tmr_load = 1'b1;
        cyc();
        tmr_load = 1'b0;
        for (int i = 0; i < 50 && !cpu_irq; i++) cyc();
        chk("timer_cpu_irq", {31'h0, cpu_irq}, 32'h1);
        wr(2'd2, 32'h5);
        chk("timer_pulse", {24'h0, irq_clear}, 32'h20);
        cyc();
        chk("timer_irq_dropped", {31'h0, tmr_irq}, 32'h0);
        cyc();
        cyc();
        chk("timer_cpu_low", {31'h0, cpu_irq}, 32'h0);

        // Reset during the clear pulse
        tmr_load = 1'b1;
        cyc();
        tmr_load = 1'b0;
        for (int i = 0; i < 50 && !cpu_irq; i++) cyc();
        chk("timer2_cpu_irq", {31'h0, cpu_irq}, 32'h1);
        rd(2'd2);
        chk("timer2_vector", data_out, 32'h8000_0005);
        wr(2'd2, 32'h5);
        chk("timer2_pulse", {24'h0, irq_clear}, 32'h20);
        reset = 1'b1;
        #1;
        chk("rst_mid_cpu_irq",   {31'h0, cpu_irq}, 32'h0);
        chk("rst_mid_irq_clear", {24'h0, irq_clear}, 32'h0);
        chk("rst_mid_data_out",  data_out, 32'h0);
        cyc();
        cyc();
        reset = 1'b0;
        rd(2'd0);
        chk("post_reset_mask", data_out, 32'h0);
        cyc();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
